// File: rtl/lidar_pwm_frontend.sv
// ---------------------------------------------------------------------------
// lidar_pwm_frontend
//
// Three-channel LIDAR front-end. Each channel measures the high time of a
// distance sensor's PWM output in clk cycles and turns it into an
// obstacle-near level with hysteresis. A per-channel watchdog flags sensors
// whose line has stopped toggling, whether it is stuck low or stuck high.
// near[0] feeds sensor1 of the speaker-priority state machine, near[2] feeds
// sensor3.
//
// Parameters
//   CNT_W    width of the pulse-width and watchdog counters
//   NEAR_TH  widths below this many cycles mean "near"
//   HYST     extra width above NEAR_TH needed before "near" clears
//   TIMEOUT  cycles without a rising edge before a channel is faulted
//            (must be below 2**CNT_W)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active high, overrides everything
//   ena        design enable; 0 abandons measurements and freezes state
//   pwm_in     [2:0] raw sensor PWM, asynchronous to clk
//   near       [2:0] registered obstacle-near level per channel
//   fault      [2:0] registered sensor-fault level per channel
//   meas_done  [2:0] one-cycle pulse per completed width measurement
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// lidar_pwm_channel
//
// One independent measurement channel. Channels share nothing except the
// clock, reset and enable, so the top level is simply three of these.
//
// Ports
//   clk, rst, ena   as for the top level
//   pwm             raw PWM input for this channel
//   near            obstacle-near level
//   fault           sensor-fault level
//   meas_done       one-cycle pulse per completed measurement
// ---------------------------------------------------------------------------
module lidar_pwm_channel #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned NEAR_TH = 1000,
    parameter int unsigned HYST    = 100,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic pwm,
    output logic near,
    output logic fault,
    output logic meas_done
);

    // Thresholds are widened by one bit so NEAR_TH + HYST cannot wrap
    // when it is compared against a full-scale width.
    localparam logic [CNT_W:0]   NEAR_LIM  = (CNT_W + 1)'(NEAR_TH);
    localparam logic [CNT_W:0]   CLEAR_LIM = (CNT_W + 1)'(NEAR_TH + HYST);
    localparam logic [CNT_W-1:0] WD_LIM    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] WD_PRE    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             sync_q1;
    logic             sync_q2;
    logic             s_d;
    logic             s_dd;
    logic             rise;
    logic             fall;
    logic             level;

    logic [CNT_W-1:0] width_cnt;
    logic [CNT_W-1:0] width_nxt;
    logic [CNT_W-1:0] wd_cnt;
    logic [CNT_W-1:0] wd_nxt;
    logic             armed;
    logic             armed_nxt;
    logic             near_nxt;
    logic             fault_nxt;
    logic             done_nxt;

    // Two-flop synchronizer (sync_q2 is the synchronized level) followed by
    // two history flops. Edges are taken between the history stages, which
    // places every decision three clk edges after pwm first samples a new
    // level. This chain runs regardless of ena so it never holds stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            s_d     <= 1'b0;
            s_dd    <= 1'b0;
        end else begin
            sync_q1 <= pwm;
            sync_q2 <= sync_q1;
            s_d     <= sync_q2;
            s_dd    <= s_d;
        end
    end

    assign level = s_d;
    assign rise  = s_d & ~s_dd;
    assign fall  = ~s_d & s_dd;

    // Next-state logic for the width counter, watchdog and outputs.
    // The watchdog is evaluated last so a timeout overrides anything the
    // width logic decided in the same cycle, except that a rising edge
    // always reloads the watchdog and prevents the fault.
    always_comb begin
        width_nxt = width_cnt;
        wd_nxt    = wd_cnt;
        armed_nxt = armed;
        near_nxt  = near;
        fault_nxt = fault;
        done_nxt  = 1'b0;

        if (!ena) begin
            armed_nxt = 1'b0;
        end else begin
            if (rise) begin
                width_nxt = CNT_ONE;
                armed_nxt = 1'b1;
            end else if (level && armed && (width_cnt != CNT_MAX)) begin
                width_nxt = width_cnt + CNT_ONE;
            end

            // A full-scale width may be a truncated count, so it is
            // always treated as far rather than trusted numerically.
            if (fall && armed) begin
                done_nxt  = 1'b1;
                armed_nxt = 1'b0;
                fault_nxt = 1'b0;
                if (width_cnt == CNT_MAX) begin
                    near_nxt = 1'b0;
                end else if ({1'b0, width_cnt} < NEAR_LIM) begin
                    near_nxt = 1'b1;
                end else if ({1'b0, width_cnt} >= CLEAR_LIM) begin
                    near_nxt = 1'b0;
                end
            end

            if (rise) begin
                wd_nxt = '0;
            end else if (wd_cnt >= WD_PRE) begin
                wd_nxt    = WD_LIM;
                fault_nxt = 1'b1;
                near_nxt  = 1'b0;
                armed_nxt = 1'b0;
            end else begin
                wd_nxt = wd_cnt + CNT_ONE;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            width_cnt <= '0;
            wd_cnt    <= '0;
            armed     <= 1'b0;
            near      <= 1'b0;
            fault     <= 1'b0;
            meas_done <= 1'b0;
        end else begin
            width_cnt <= width_nxt;
            wd_cnt    <= wd_nxt;
            armed     <= armed_nxt;
            near      <= near_nxt;
            fault     <= fault_nxt;
            meas_done <= done_nxt;
        end
    end

endmodule

module lidar_pwm_frontend #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned NEAR_TH = 1000,
    parameter int unsigned HYST    = 100,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [2:0] pwm_in,
    output logic [2:0] near,
    output logic [2:0] fault,
    output logic [2:0] meas_done
);

    // One fully independent channel per sensor.
    for (genvar i = 0; i < 3; i++) begin : g_chan
        lidar_pwm_channel #(
            .CNT_W  (CNT_W),
            .NEAR_TH(NEAR_TH),
            .HYST   (HYST),
            .TIMEOUT(TIMEOUT)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .ena      (ena),
            .pwm      (pwm_in[i]),
            .near     (near[i]),
            .fault    (fault[i]),
            .meas_done(meas_done[i])
        );
    end

endmodule

// File: tb/tb_lidar_pwm_frontend.sv
// ---------------------------------------------------------------------------
// tb_lidar_pwm_frontend
//
// Self-checking bench for lidar_pwm_frontend with CNT_W=8, NEAR_TH=10,
// HYST=4, TIMEOUT=100. A behavioural model tracks each channel in terms of
// pulse timestamps (width = fall time minus rise time, watchdog = enabled
// cycles since the last accepted rise) and the scenario tasks also check
// fixed expectations for the named cases.
// ---------------------------------------------------------------------------
module tb_lidar_pwm_frontend;

    localparam int CNT_W   = 8;
    localparam int NEAR_TH = 10;
    localparam int HYST    = 4;
    localparam int TIMEOUT = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [2:0] pwm_in;
    logic [2:0] near;
    logic [2:0] fault;
    logic [2:0] meas_done;

    int checks   = 0;
    int failures = 0;

    lidar_pwm_frontend #(
        .CNT_W  (CNT_W),
        .NEAR_TH(NEAR_TH),
        .HYST   (HYST),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .pwm_in   (pwm_in),
        .near     (near),
        .fault    (fault),
        .meas_done(meas_done)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit [2:0]   samp_q[$];
    int         cyc;
    int         en_cnt;
    int         rise_cyc [3];
    int         wd_ref   [3];
    bit         m_armed  [3];
    logic       m_lvl;
    logic       m_prv;
    logic [2:0] exp_near  = 3'b000;
    logic [2:0] exp_fault = 3'b000;
    logic [2:0] exp_md    = 3'b000;

    int md_seen [3] = '{0, 0, 0};

    // Hysteresis rule applied to one completed pulse width.
    function automatic logic near_rule(input int width, input logic prev);
        if (width >= (1 << CNT_W) - 1) return 1'b0;
        if (width < NEAR_TH) return 1'b1;
        if (width >= NEAR_TH + HYST) return 1'b0;
        return prev;
    endfunction

    // Model: the design acts on the PWM level seen three edges earlier.
    always @(posedge clk) begin
        if (rst) begin
            samp_q.delete();
            repeat (5) samp_q.push_back(3'b000);
            cyc = 0;
            en_cnt = 0;
            exp_near = 3'b000;
            exp_fault = 3'b000;
            exp_md = 3'b000;
            for (int c = 0; c < 3; c++) begin
                rise_cyc[c] = 0;
                wd_ref[c] = 0;
                m_armed[c] = 1'b0;
            end
        end else begin
            samp_q.push_back(pwm_in);
            void'(samp_q.pop_front());
            cyc++;
            if (ena) en_cnt++;
            exp_md = 3'b000;
            for (int c = 0; c < 3; c++) begin
                m_lvl = samp_q[1][c];
                m_prv = samp_q[0][c];
                if (!ena) begin
                    m_armed[c] = 1'b0;
                end else begin
                    if (!m_lvl && m_prv && m_armed[c]) begin
                        exp_md[c] = 1'b1;
                        m_armed[c] = 1'b0;
                        exp_fault[c] = 1'b0;
                        exp_near[c] = near_rule(cyc - rise_cyc[c], exp_near[c]);
                    end
                    if (m_lvl && !m_prv) begin
                        rise_cyc[c] = cyc;
                        wd_ref[c] = en_cnt;
                        m_armed[c] = 1'b1;
                    end else if (en_cnt - wd_ref[c] >= TIMEOUT) begin
                        exp_fault[c] = 1'b1;
                        exp_near[c] = 1'b0;
                        m_armed[c] = 1'b0;
                    end
                end
            end
        end
    end

    // Count meas_done pulses per channel, sampled just after each edge.
    always @(posedge clk) begin
        #1;
        for (int c = 0; c < 3; c++) begin
            if (meas_done[c] === 1'b1) md_seen[c]++;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic hold(input logic [2:0] pat, input int n);
        pwm_in = pat;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst = 1'b1;
        ena = 1'b1;
        pwm_in = 3'b111;
        tick();
        tick();
        rst = 1'b0;
        pwm_in = 3'b000;
        tick();
        checks++;
        if ({near, fault, meas_done} !== 9'b0) begin
            failures++;
            $display("[TB] FAIL reset_state got near=%b fault=%b done=%b want all 0",
                     near, fault, meas_done);
        end
        checks++;
        if ({near, fault, meas_done} !== {exp_near, exp_fault, exp_md}) begin
            failures++;
            $display("[TB] FAIL reset_model got %b/%b/%b want %b/%b/%b",
                     near, fault, meas_done, exp_near, exp_fault, exp_md);
        end
    endtask

    task automatic test_single_pulse();
        int md0;
        $display("[TB] test_single_pulse");
        md0 = md_seen[0];
        hold(3'b001, 6);
        pwm_in = 3'b000;
        repeat (3) tick();
        checks++;
        if (near[0] !== 1'b0 || meas_done !== 3'b000) begin
            failures++;
            $display("[TB] FAIL pulse_early got near0=%b done=%b want 0/000",
                     near[0], meas_done);
        end
        tick();
        checks++;
        if (near[0] !== 1'b1 || meas_done !== 3'b001) begin
            failures++;
            $display("[TB] FAIL pulse_latency got near0=%b done=%b want 1/001",
                     near[0], meas_done);
        end
        tick();
        checks++;
        if (meas_done !== 3'b000) begin
            failures++;
            $display("[TB] FAIL pulse_one_cycle got done=%b want 000", meas_done);
        end
        checks++;
        if (md_seen[0] - md0 != 1) begin
            failures++;
            $display("[TB] FAIL pulse_count got %0d want 1", md_seen[0] - md0);
        end
    endtask

    task automatic test_hysteresis();
        int   widths [3] = '{12, 14, 9};
        logic want   [3] = '{1'b1, 1'b0, 1'b1};
        int   md0;
        $display("[TB] test_hysteresis");
        for (int k = 0; k < 3; k++) begin
            md0 = md_seen[0];
            hold(3'b001, widths[k]);
            hold(3'b000, 8);
            checks++;
            if (near[0] !== want[k] || md_seen[0] - md0 != 1) begin
                failures++;
                $display("[TB] FAIL hyst_w%0d got near0=%b pulses=%0d want %b/1",
                         widths[k], near[0], md_seen[0] - md0, want[k]);
            end
            checks++;
            if ({near, fault} !== {exp_near, exp_fault}) begin
                failures++;
                $display("[TB] FAIL hyst_model_w%0d got %b/%b want %b/%b",
                         widths[k], near, fault, exp_near, exp_fault);
            end
        end
    endtask

    task automatic test_simultaneous();
        $display("[TB] test_simultaneous");
        hold(3'b100, 3);
        hold(3'b110, 1);
        hold(3'b111, 9);
        pwm_in = 3'b000;
        repeat (3) tick();
        checks++;
        if (meas_done !== 3'b000) begin
            failures++;
            $display("[TB] FAIL simul_early got done=%b want 000", meas_done);
        end
        tick();
        checks++;
        if (meas_done !== 3'b111 || near !== 3'b001) begin
            failures++;
            $display("[TB] FAIL simul got done=%b near=%b want 111/001", meas_done, near);
        end
    endtask

    task automatic test_watchdog();
        $display("[TB] test_watchdog");
        pwm_in = 3'b000;
        for (int i = 0; i < 110; i++) begin
            tick();
            checks++;
            if ({near, fault, meas_done} !== {exp_near, exp_fault, exp_md}) begin
                failures++;
                $display("[TB] FAIL wd_track i=%0d got %b/%b/%b want %b/%b/%b", i,
                         near, fault, meas_done, exp_near, exp_fault, exp_md);
            end
        end
        checks++;
        if (fault[2] !== 1'b1 || near[2] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wd_dead got fault2=%b near2=%b want 1/0", fault[2], near[2]);
        end
        hold(3'b100, 20);
        hold(3'b000, 6);
        checks++;
        if (fault[2] !== 1'b0 || near[2] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wd_recover got fault2=%b near2=%b want 0/0", fault[2], near[2]);
        end
    endtask

    task automatic test_ena();
        int md1;
        $display("[TB] test_ena");
        hold(3'b010, 5);
        hold(3'b000, 8);
        checks++;
        if (near[1] !== 1'b1 || fault[1] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ena_pre got near1=%b fault1=%b want 1/0", near[1], fault[1]);
        end
        md1 = md_seen[1];
        pwm_in = 3'b010;
        for (int i = 1; i <= 20; i++) begin
            ena = !(i >= 5 && i <= 8);
            tick();
        end
        ena = 1'b1;
        hold(3'b000, 8);
        checks++;
        if (md_seen[1] != md1 || near[1] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ena_abandon got pulses=%0d near1=%b want 0/1",
                     md_seen[1] - md1, near[1]);
        end
        hold(3'b010, 20);
        hold(3'b000, 8);
        checks++;
        if (near[1] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ena_far got near1=%b want 0", near[1]);
        end
        hold(3'b010, 5);
        hold(3'b000, 8);
        checks++;
        if (near[1] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ena_recover got near1=%b want 1", near[1]);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int md0;
        $display("[TB] test_reset_mid_pulse");
        hold(3'b001, 5);
        md0 = md_seen[0];
        rst = 1'b1;
        tick();
        pwm_in = 3'b000;
        tick();
        rst = 1'b0;
        repeat (8) tick();
        checks++;
        if (md_seen[0] != md0 || {near, fault, meas_done} !== 9'b0) begin
            failures++;
            $display("[TB] FAIL rst_mid got pulses=%0d near=%b fault=%b want 0/000/000",
                     md_seen[0] - md0, near, fault);
        end
    endtask

    task automatic test_random();
        int   remain [3] = '{0, 0, 0};
        logic lv     [3] = '{1'b0, 1'b0, 1'b0};
        $display("[TB] test_random");
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < 3; c++) begin
                if (remain[c] == 0) begin
                    lv[c] = ~lv[c];
                    if (lv[c])
                        remain[c] = ($urandom_range(0, 24) == 0) ? 120 : $urandom_range(1, 20);
                    else
                        remain[c] = ($urandom_range(0, 24) == 0) ? 110 : $urandom_range(1, 12);
                end
                remain[c]--;
                pwm_in[c] = lv[c];
            end
            ena = ($urandom_range(0, 49) != 0);
            tick();
            checks++;
            if ({near, fault, meas_done} !== {exp_near, exp_fault, exp_md}) begin
                failures++;
                $display("[TB] FAIL random i=%0d got %b/%b/%b want %b/%b/%b", i,
                         near, fault, meas_done, exp_near, exp_fault, exp_md);
            end
        end
        ena = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_hysteresis();
        test_simultaneous();
        test_watchdog();
        test_ena();
        test_reset_mid_pulse();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
